// File: rtl/maxpool_flatten.sv
// 2x2 stride-2 max-pool of two Layer-0 maps into Layer-1 banks, with a
// kernel-interleaved flatten copy written to the Layer-2 bank.
module maxpool_flatten #(
  parameter int unsigned DATA_W = 20,
  parameter int unsigned IN_W   = 64,
  parameter int unsigned ADDR_W = 12
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              crd,
  output logic [ADDR_W-1:0] caddr_rd,
  input  logic [DATA_W-1:0] cdata_rd,
  output logic              cwr,
  output logic [ADDR_W-1:0] caddr_wr,
  output logic [DATA_W-1:0] cdata_wr,
  output logic [2:0]        csel
);

  localparam int unsigned P_W   = IN_W / 2;
  localparam int unsigned IN_LG = $clog2(IN_W);
  localparam int unsigned CNT_W = $clog2(P_W);

  typedef logic [ADDR_W-1:0] addr_t;
  typedef logic [CNT_W-1:0]  cnt_t;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_RD0  = 3'd1,
    S_RD1  = 3'd2,
    S_RD2  = 3'd3,
    S_RD3  = 3'd4,
    S_WR1  = 3'd5,
    S_WR2  = 3'd6,
    S_DONE = 3'd7
  } state_t;

  state_t              state_q, state_nxt;
  logic                k_q, k_nxt;
  cnt_t                r_q, r_nxt;
  cnt_t                c_q, c_nxt;
  logic [DATA_W-1:0]   max_q, max_nxt;

  logic                busy_d, done_d, crd_d, cwr_d;
  addr_t               caddr_rd_d, caddr_wr_d;
  logic [DATA_W-1:0]   cdata_wr_d;
  logic [2:0]          csel_d;

  logic                last_pos;
  addr_t               r_a, c_a, base_a, pix_a;

  assign last_pos = k_q && (r_q == CNT_W'(P_W - 1)) && (c_q == CNT_W'(P_W - 1));

  // Sequencer: four window reads, two writes, then advance c, r, k.
  always_comb begin
    state_nxt = state_q;
    k_nxt     = k_q;
    r_nxt     = r_q;
    c_nxt     = c_q;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          state_nxt = S_RD0;
          k_nxt     = 1'b0;
          r_nxt     = '0;
          c_nxt     = '0;
        end
      end
      S_RD0: state_nxt = S_RD1;
      S_RD1: state_nxt = S_RD2;
      S_RD2: state_nxt = S_RD3;
      S_RD3: state_nxt = S_WR1;
      S_WR1: state_nxt = S_WR2;
      S_WR2: begin
        if (last_pos) begin
          state_nxt = S_DONE;
        end else begin
          state_nxt = S_RD0;
          if (c_q == CNT_W'(P_W - 1)) begin
            c_nxt = '0;
            if (r_q == CNT_W'(P_W - 1)) begin
              r_nxt = '0;
              k_nxt = 1'b1;
            end else begin
              r_nxt = r_q + CNT_W'(1);
            end
          end else begin
            c_nxt = c_q + CNT_W'(1);
          end
        end
      end
      S_DONE: state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Running maximum over the window; strict compare so ties keep the old value.
  always_comb begin
    max_nxt = max_q;
    unique case (state_q)
      S_RD0: max_nxt = cdata_rd;
      S_RD1, S_RD2, S_RD3: begin
        if (cdata_rd > max_q) max_nxt = cdata_rd;
      end
      default: max_nxt = max_q;
    endcase
  end

  // Addresses derived from the upcoming position so the buses can be registered.
  always_comb begin
    r_a    = addr_t'(r_nxt);
    c_a    = addr_t'(c_nxt);
    base_a = (r_a << (IN_LG + 1)) + (c_a << 1);
    pix_a  = (r_a << CNT_W) + c_a;
  end

  // Next-cycle output values; every bus idles at zero outside its strobe.
  always_comb begin
    busy_d     = 1'b0;
    done_d     = 1'b0;
    crd_d      = 1'b0;
    cwr_d      = 1'b0;
    caddr_rd_d = '0;
    caddr_wr_d = '0;
    cdata_wr_d = '0;
    csel_d     = 3'd0;
    unique case (state_nxt)
      S_IDLE: busy_d = 1'b0;
      S_RD0, S_RD1, S_RD2, S_RD3: begin
        busy_d = 1'b1;
        crd_d  = 1'b1;
        csel_d = 3'd1 + {2'b00, k_nxt};
        unique case (state_nxt)
          S_RD0:   caddr_rd_d = base_a;
          S_RD1:   caddr_rd_d = base_a + addr_t'(1);
          S_RD2:   caddr_rd_d = base_a + addr_t'(IN_W);
          default: caddr_rd_d = base_a + addr_t'(IN_W + 1);
        endcase
      end
      S_WR1: begin
        busy_d     = 1'b1;
        cwr_d      = 1'b1;
        csel_d     = 3'd3 + {2'b00, k_nxt};
        caddr_wr_d = pix_a;
        cdata_wr_d = max_nxt;
      end
      S_WR2: begin
        busy_d     = 1'b1;
        cwr_d      = 1'b1;
        csel_d     = 3'd5;
        caddr_wr_d = (pix_a << 1) + addr_t'(k_nxt);
        cdata_wr_d = max_nxt;
      end
      S_DONE: begin
        busy_d = 1'b1;
        done_d = 1'b1;
      end
      default: busy_d = 1'b0;
    endcase
  end

  // State, counters and the running maximum.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      k_q     <= 1'b0;
      r_q     <= '0;
      c_q     <= '0;
      max_q   <= '0;
    end else begin
      state_q <= state_nxt;
      k_q     <= k_nxt;
      r_q     <= r_nxt;
      c_q     <= c_nxt;
      max_q   <= max_nxt;
    end
  end

  // Registered outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      busy     <= 1'b0;
      done     <= 1'b0;
      crd      <= 1'b0;
      cwr      <= 1'b0;
      caddr_rd <= '0;
      caddr_wr <= '0;
      cdata_wr <= '0;
      csel     <= 3'd0;
    end else begin
      busy     <= busy_d;
      done     <= done_d;
      crd      <= crd_d;
      cwr      <= cwr_d;
      caddr_rd <= caddr_rd_d;
      caddr_wr <= caddr_wr_d;
      cdata_wr <= cdata_wr_d;
      csel     <= csel_d;
    end
  end

endmodule

// File: tb/tb_maxpool_flatten.sv
// Bench for maxpool_flatten: memory model, protocol monitor and a pooling
// reference computed directly from the Layer-0 maps.
module tb_maxpool_flatten;

  localparam int unsigned DATA_W = 20;
  localparam int unsigned IN_W   = 64;
  localparam int unsigned ADDR_W = 12;
  localparam int          P_W    = 32;
  localparam int          RUN_CYC = 12289;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              start = 1'b0;
  logic              busy, done, crd, cwr;
  logic [ADDR_W-1:0] caddr_rd, caddr_wr;
  logic [DATA_W-1:0] cdata_rd, cdata_wr;
  logic [2:0]        csel;

  always #5 clk = ~clk;

  maxpool_flatten #(.DATA_W(DATA_W), .IN_W(IN_W), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .reset(reset), .start(start), .busy(busy), .done(done),
    .crd(crd), .caddr_rd(caddr_rd), .cdata_rd(cdata_rd),
    .cwr(cwr), .caddr_wr(caddr_wr), .cdata_wr(cdata_wr), .csel(csel)
  );

  logic [19:0] l0 [0:1][0:4095];
  logic [19:0] l1 [0:1][0:1023];
  logic [19:0] l2 [0:2047];
  logic [19:0] ref_p [0:1][0:1023];

  assign cdata_rd = (crd && csel == 3'd1) ? l0[0][caddr_rd] :
                    (crd && csel == 3'd2) ? l0[1][caddr_rd] : '0;

  int          n_rd = 0, n_wr = 0, proto_err = 0;
  logic [14:0] rd_q [$];
  logic [34:0] wr_q [$];
  logic        clr_mem = 1'b0;

  // Memory write port plus protocol observation, sampled mid-cycle.
  always @(negedge clk) begin
    if (clr_mem) begin
      for (int i = 0; i < 1024; i++) begin
        l1[0][i] = 'x;
        l1[1][i] = 'x;
      end
      for (int i = 0; i < 2048; i++) l2[i] = 'x;
    end
    if (crd && cwr) proto_err++;
    if (crd) begin
      n_rd++;
      rd_q.push_back({csel, caddr_rd});
      if (csel != 3'd1 && csel != 3'd2) proto_err++;
    end else if (caddr_rd != '0) proto_err++;
    if (cwr) begin
      n_wr++;
      wr_q.push_back({csel, caddr_wr, cdata_wr});
      case (csel)
        3'd3: l1[0][caddr_wr[9:0]] = cdata_wr;
        3'd4: l1[1][caddr_wr[9:0]] = cdata_wr;
        3'd5: l2[caddr_wr[10:0]] = cdata_wr;
        default: proto_err++;
      endcase
    end else if (caddr_wr != '0 || cdata_wr != '0) proto_err++;
    if (!crd && !cwr && csel != 3'd0) proto_err++;
  end

  int checks = 0;
  int errors = 0;
  int rdq0, wrq0, pe0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_outputs();
    clr_mem = 1'b1;
    repeat (2) @(negedge clk);
    clr_mem = 1'b0;
  endtask

  task automatic build_ref();
    logic [19:0] m, v;
    for (int k = 0; k < 2; k++)
      for (int r = 0; r < P_W; r++)
        for (int c = 0; c < P_W; c++) begin
          m = 0;
          for (int dy = 0; dy < 2; dy++)
            for (int dx = 0; dx < 2; dx++) begin
              v = l0[k][(2*r + dy) * 64 + 2*c + dx];
              if (v > m) m = v;
            end
          ref_p[k][r*P_W + c] = m;
        end
  endtask

  task automatic run_job(input int hold, input string tag);
    int n, rd0, wr0;
    rd0 = n_rd; wr0 = n_wr; pe0 = proto_err;
    rdq0 = rd_q.size(); wrq0 = wr_q.size();
    @(negedge clk); start = 1'b1;
    @(negedge clk); n = 1;
    if (hold == 0) start = 1'b0;
    chk({tag, " busy_after_start"}, 64'(busy), 64'd1);
    while (!done && n < 20000) begin
      @(negedge clk);
      n++;
      if (n > hold) start = 1'b0;
    end
    start = 1'b0;
    chk({tag, " done_latency"}, 64'(n), 64'(RUN_CYC));
    chk({tag, " busy_at_done"}, 64'(busy), 64'd1);
    @(negedge clk);
    chk({tag, " idle_after_done"}, 64'({done, busy}), 64'd0);
    repeat (2) @(negedge clk);
    chk({tag, " rd_cycles"}, 64'(n_rd - rd0), 64'd8192);
    chk({tag, " wr_cycles"}, 64'(n_wr - wr0), 64'd4096);
  endtask

  task automatic verify(input string tag);
    int bad, idx;
    logic [14:0] er;
    logic [34:0] ew;
    bad = 0;
    for (int k = 0; k < 2; k++)
      for (int i = 0; i < 1024; i++) begin
        if (l1[k][i] !== ref_p[k][i]) bad++;
        if (l2[2*i + k] !== ref_p[k][i]) bad++;
      end
    chk({tag, " mem_contents"}, 64'(bad), 64'd0);
    bad = 0; idx = rdq0;
    for (int k = 0; k < 2; k++)
      for (int r = 0; r < P_W; r++)
        for (int c = 0; c < P_W; c++)
          for (int n = 0; n < 4; n++) begin
            er = {3'(1 + k), 12'((2*r + n/2) * 64 + 2*c + n%2)};
            if (idx >= rd_q.size() || rd_q[idx] !== er) bad++;
            idx++;
          end
    chk({tag, " rd_sequence"}, 64'(bad), 64'd0);
    bad = 0; idx = wrq0;
    for (int k = 0; k < 2; k++)
      for (int p = 0; p < 1024; p++) begin
        ew = {3'(3 + k), 12'(p), ref_p[k][p]};
        if (idx >= wr_q.size() || wr_q[idx] !== ew) bad++;
        idx++;
        ew = {3'd5, 12'(2*p + k), ref_p[k][p]};
        if (idx >= wr_q.size() || wr_q[idx] !== ew) bad++;
        idx++;
      end
    chk({tag, " wr_sequence"}, 64'(bad), 64'd0);
    chk({tag, " protocol"}, 64'(proto_err - pe0), 64'd0);
  endtask

  task automatic load_case1();
    for (int a = 0; a < 4096; a++) begin
      l0[0][a] = 20'(a);
      l0[1][a] = '0;
    end
  endtask

  task automatic check_case1(input string tag);
    chk({tag, " l1k0_0"}, 64'(l1[0][0]), 64'h00041);
    chk({tag, " l1k0_1023"}, 64'(l1[0][1023]), 64'h00FFF);
    chk({tag, " l2_0"}, 64'(l2[0]), 64'h00041);
    chk({tag, " l2_1"}, 64'(l2[1]), 64'h0);
    chk({tag, " l2_2047"}, 64'(l2[2047]), 64'h0);
  endtask

  initial begin
    int n, rd_s, wr_s, bad;
    #1 reset = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_outputs", 64'({busy, done, crd, cwr, caddr_rd, caddr_wr, cdata_wr, csel}), 64'd0);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    chk("idle_outputs", 64'({busy, done, crd, cwr, caddr_rd, caddr_wr, cdata_wr, csel}), 64'd0);

    // Ramp map with start held high for the first 1000 busy cycles.
    load_case1();
    build_ref();
    clear_outputs();
    run_job(1000, "case1");
    verify("case1");
    check_case1("case1");

    // Unsigned compare with ties at full scale.
    for (int a = 0; a < 4096; a++) begin
      l0[0][a] = 20'($urandom);
      l0[1][a] = '0;
    end
    l0[1][0] = 20'd5; l0[1][1] = 20'hFFFFF; l0[1][64] = 20'd3; l0[1][65] = 20'hFFFFF;
    build_ref();
    clear_outputs();
    run_job(0, "case2");
    verify("case2");
    chk("case2 l1k1_0", 64'(l1[1][0]), 64'hFFFFF);
    chk("case2 l2_1", 64'(l2[1]), 64'hFFFFF);

    // Random data: full range on one map, tie-heavy small values on the other.
    for (int a = 0; a < 4096; a++) begin
      l0[0][a] = 20'($urandom);
      l0[1][a] = 20'($urandom_range(0, 7));
    end
    build_ref();
    clear_outputs();
    run_job(0, "random");
    verify("random");

    // Asynchronous reset in the 500th busy cycle.
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0; n = 1;
    while (n < 500) begin
      @(negedge clk);
      n++;
    end
    #2 reset = 1'b0;
    #1 chk("midrun_reset_outputs", 64'({busy, done, crd, cwr, caddr_rd, caddr_wr, cdata_wr, csel}), 64'd0);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    rd_s = n_rd; wr_s = n_wr;
    repeat (30) @(negedge clk);
    chk("post_reset_no_strobes", 64'((n_rd - rd_s) + (n_wr - wr_s)), 64'd0);
    chk("post_reset_idle", 64'(busy), 64'd0);
    load_case1();
    build_ref();
    clear_outputs();
    run_job(0, "rerun");
    verify("rerun");
    check_case1("rerun");

    // Constant maps.
    for (int a = 0; a < 4096; a++) begin
      l0[0][a] = 20'h12345;
      l0[1][a] = 20'h12345;
    end
    build_ref();
    clear_outputs();
    run_job(0, "const");
    verify("const");
    bad = 0;
    for (int i = 0; i < 1024; i++) begin
      if (l1[0][i] !== 20'h12345) bad++;
      if (l1[1][i] !== 20'h12345) bad++;
    end
    for (int i = 0; i < 2048; i++) if (l2[i] !== 20'h12345) bad++;
    chk("const all_words", 64'(bad), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
